// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: tick-driven mm:ss.cc BCD stopwatch with run/pause/clear and lap freeze
module stopwatch_bcd #(
  parameter int TICKS_PER_CS = 1,
  parameter int MAX_MIN      = 59
) (
  input  logic        in_clk,
  input  logic        reset,
  input  logic        tick_en,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        lap,
  output logic        running,
  output logic        lap_active,
  output logic [23:0] disp_digits,
  output logic        wrap
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  localparam logic [15:0] LAST    = 16'(TICKS_PER_CS - 1);
  localparam logic [7:0]  MAX_BCD = 8'((MAX_MIN / 10) * 16 + MAX_MIN % 10);
  state_t      state_q;
  logic        running_q, lap_q, wrap_q;
  logic [15:0] presc_q;
  logic [23:0] cnt_q, latch_q, cnt_d;
  logic        roll;
  // ripple-carry BCD increment; digit 3 (seconds tens) wraps at 5, the rest at 9
  function automatic logic [23:0] bcd_inc(input logic [23:0] v);
    logic       c;
    logic [3:0] d, l;
    logic [23:0] r;
    c = 1'b1;
    r = v;
    for (int i = 0; i < 6; i++) begin
      d = v[4*i +: 4];
      l = (i == 3) ? 4'd5 : 4'd9;
      r[4*i +: 4] = c ? ((d == l) ? 4'd0 : d + 4'd1) : d;
      c = c & (d == l);
    end
    return r;
  endfunction
  // next count value; the minute field rolls back to zero after MAX_MIN:59.99
  always_comb begin
    roll  = (cnt_q[15:0] == 16'h5999) && (cnt_q[23:16] == MAX_BCD);
    cnt_d = roll ? 24'd0 : bcd_inc(cnt_q);
  end
  // control FSM, prescaler, count and lap latch with registered outputs
  always_ff @(posedge in_clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      lap_q     <= 1'b0;
      wrap_q    <= 1'b0;
      presc_q   <= 16'd0;
      cnt_q     <= 24'd0;
      latch_q   <= 24'd0;
    end else begin
      wrap_q <= 1'b0;
      if (clear) begin
        cnt_q   <= 24'd0;
        presc_q <= 16'd0;
        lap_q   <= 1'b0;
        if (state_q == PAUSE) state_q <= IDLE;
        running_q <= (state_q == RUN);
      end else begin
        if (state_q == RUN && tick_en) begin
          presc_q <= (presc_q == LAST) ? 16'd0 : presc_q + 16'd1;
          if (presc_q == LAST) begin
            cnt_q  <= cnt_d;
            wrap_q <= roll;
          end
        end
        if (start_stop) begin
          state_q   <= (state_q == RUN) ? PAUSE : RUN;
          running_q <= (state_q != RUN);
        end
        if (lap && lap_q) lap_q <= 1'b0;
        else if (lap && state_q == RUN) begin
          lap_q   <= 1'b1;
          latch_q <= cnt_q;
        end
      end
    end
  end
  assign running     = running_q;
  assign lap_active  = lap_q;
  assign wrap        = wrap_q;
  assign disp_digits = lap_q ? latch_q : cnt_q;
endmodule

// File: tb/tb_stopwatch_bcd.sv
// tb_stopwatch_bcd: scoreboard bench for stopwatch_bcd against a centisecond-integer reference model
module tb_stopwatch_bcd;
  localparam int T  = 2;
  localparam int MM = 1;
  localparam int SPAN = (MM + 1) * 6000;
  logic in_clk = 1'b0, reset = 1'b0, tick_en = 1'b0, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic running, lap_active, wrap;
  logic [23:0] disp_digits;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int mode = 0, tot = 0, pre = 0, latch = 0;
  logic lapa = 1'b0, wr = 1'b0;
  logic [26:0] q[$];

  stopwatch_bcd #(.TICKS_PER_CS(T), .MAX_MIN(MM)) dut (
    .in_clk(in_clk), .reset(reset), .tick_en(tick_en), .start_stop(start_stop),
    .clear(clear), .lap(lap), .running(running), .lap_active(lap_active),
    .disp_digits(disp_digits), .wrap(wrap)
  );

  always #5 in_clk = ~in_clk;

  function automatic logic [23:0] to_bcd(input int cs);
    int m, s, c;
    m = cs / 6000;
    s = (cs / 100) % 60;
    c = cs % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  // mode: 0 idle, 1 run, 2 pause
  task automatic step(input logic ss, input logic clr, input logic lp, input logic tk, input logic rs);
    int old;
    @(negedge in_clk);
    start_stop = ss; clear = clr; lap = lp; tick_en = tk; reset = rs;
    wr = 1'b0;
    if (!rs) begin
      mode = 0; tot = 0; pre = 0; latch = 0; lapa = 1'b0;
    end else if (clr) begin
      tot = 0; pre = 0; lapa = 1'b0;
      if (mode == 2) mode = 0;
    end else begin
      old = tot;
      if (mode == 1 && tk) begin
        pre++;
        if (pre == T) begin
          pre = 0;
          tot++;
          if (tot == SPAN) begin tot = 0; wr = 1'b1; end
        end
      end
      if (lp && lapa) lapa = 1'b0;
      else if (lp && mode == 1) begin lapa = 1'b1; latch = old; end
      if (ss) mode = (mode == 1) ? 2 : 1;
    end
    q.push_back({mode == 1, lapa, to_bcd(lapa ? latch : tot), wr});
  endtask

  always @(posedge in_clk) begin
    logic [26:0] e;
    #1;
    cyc++;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      if ({running, lap_active, disp_digits, wrap} !== e) begin
        n_bad++;
        $display("FAIL cyc %0d: got run=%b lap=%b disp=%h wrap=%b, want run=%b lap=%b disp=%h wrap=%b",
                 cyc, running, lap_active, disp_digits, wrap, e[26], e[25], e[24:1], e[0]);
      end
    end
  end

  initial begin
    repeat (3) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    repeat (150) step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    repeat (10) step(0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 1, 1);
    step(0, 0, 1, 1, 1);
    repeat (40) step(0, 0, 0, 1, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 1);
    step(1, 0, 1, 1, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 1);
    step(1, 1, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 1);
    repeat (2468) step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 1, $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 75, $urandom_range(0, 999) >= 4);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    repeat (T * SPAN - 40) step(0, 0, 0, 1, 1);
    step(0, 0, 1, 1, 1);
    repeat (30) step(0, 0, 0, 1, 1);
    step(0, 0, 1, 1, 1);
    repeat (30) step(0, 0, 0, 1, 1);
    @(posedge in_clk);
    #2;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

Tick-driven BCD stopwatch that consumes the single-cycle clock-enable pulses produced by the clock-enable divider stage and turns them into a mm:ss.cc count for display. The block sits directly downstream of the divider and directly upstream of the seven-segment driver. It owns the run/pause/clear control, the lap freeze and the display value.

## Interface
- TICKS_PER_CS, default 1: number of tick_en pulses per centisecond increment. Legal range 1..65535.
- MAX_MIN, default 59: last minute value before wrap. Legal range 1..99.
- in_clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low reset.
- tick_en  input  1  time-base enable from the divider; every in_clk cycle it is high counts as one tick.
- start_stop  input  1  single-cycle command pulse that toggles run/pause.
- clear  input  1  single-cycle command pulse that zeroes the count.
- lap  input  1  single-cycle command pulse that toggles the display freeze.
- running  output  1  high while in RUN.
- lap_active  output  1  high while the display is frozen.
- disp_digits  output  24  {min_t, min_o, sec_t, sec_o, cs_t, cs_o}, each a 4-bit BCD digit.
- wrap  output  1  one-cycle pulse on rollover from MAX_MIN:59.99 to 00:00.00.

Clock and reset are fixed: one clock (in_clk); reset is synchronous and active-low.

## Operation
- **State machine:** IDLE, RUN, PAUSE.
  - IDLE: count = 0, prescaler = 0. start_stop moves to RUN.
  - RUN: counts. start_stop moves to PAUSE.
  - PAUSE: count held. start_stop moves to RUN. clear moves to IDLE.
- **Clear in RUN:** zeroes the count and the prescaler; state stays RUN.
- **Priority:** clear beats start_stop in the same cycle; start_stop is ignored that cycle.
- **Prescaler** (16 bit):
  - Only in RUN with tick_en=1: increments.
  - At TICKS_PER_CS-1 with tick_en: resets to 0 and the count increments once.
  - PAUSE holds the prescaler value (no loss of partial centisecond).
- **Count:** six BCD digits, ripple-carry.
  - cs 00..99; sec 00..59; min 00..MAX_MIN.
  - Each digit wraps 9→0 or 5→0 with a carry into the next digit.
  - Digits never hold a non-BCD value.
- **Wrap:** MAX_MIN:59.99 + 1 → 00:00.00, wrap=1 for that cycle, state stays RUN.
- **Lap:**
  - In RUN with lap_active=0: lap sets lap_active and latches the count register value present before this edge's increment.
  - While lap_active=1: disp_digits shows the latch. A lap pulse clears lap_active.
  - In IDLE or PAUSE: lap clears lap_active if set; otherwise it is ignored.
  - clear and entry to IDLE both force lap_active=0.
- **Display:** disp_digits = lap_active ? latch : live count.
- **Simultaneous lap + start_stop in RUN:** both take effect (freeze and pause).

## Timing
- **Reset** (reset=0 at an edge), next cycle:
  - state=IDLE, running=0, lap_active=0, wrap=0, disp_digits=24'h000000.
  - Prescaler and latch = 0.
- **Reset mid-count:** takes effect at the next edge; no wrap pulse is generated.
- **Registers:** all outputs registered; no combinational path from inputs to outputs.
- **Command latency:** running changes on the edge that samples start_stop.
- **Count latency:** the count increments on the edge that samples the qualifying tick_en.
  - disp_digits shows the new value in the following cycle when not frozen.
- **wrap latency:** high in the same cycle that disp_digits first reads 00:00.00 after rollover (unfrozen case).
- **Lap latch:** lap_active and the latch update on the same edge.
- **Throughput:** tick_en high on consecutive cycles with TICKS_PER_CS=1 gives one increment per cycle; no ticks are dropped.

## Test plan
1. **Reset, then start:** hold reset=0 for 3 cycles, then start_stop pulse, then 150 tick_en pulses (TICKS_PER_CS=1) → running=1, disp_digits=24'h000150.
2. **Prescaler pause:** TICKS_PER_CS=4; start, 6 ticks, pause, 10 idle cycles with tick_en=1, resume, 2 ticks → count 00:00.02.
3. **Rollover:** MAX_MIN=1; run to 01:59.99, then one tick → disp 24'h000000 and wrap=1 for exactly one cycle.
4. **Lap freeze:** at count 00:00.37, lap pulse, then 20 ticks → disp stays 24'h000037; second lap → disp 24'h000057.
5. **Clear priority:** clear and start_stop in the same cycle while in PAUSE → state IDLE, running=0, disp 0, lap_active=0.
6. **Mid-run reset:** reset=0 for 1 cycle at 00:12.34 while in RUN → all outputs at reset values, wrap stays 0.
